cpu_trace_buffer: RTL
=====================

# cpu_trace_buffer

Synthesizable instruction-trace capture unit for the multicycle CPU, replacing ad-hoc waveform probing of `PCAddress`/`IReg_out` with an on-chip circular history. It sits beside `CPU`, samples `{PC, IR}` on each capture strobe (normally `IRWrite`), and stops on a PC-match trigger after a programmable number of post-trigger entries. It is parametrised in data width and depth. The frozen history is drained oldest-first through a one-entry-per-request read port.

## Interface

Parameters:

- `DATA_W`, 32: PC and IR width.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width. Derived; do not override.
- `STATE_W`, 4: width of the FSM state field. Used only with `TRACE_STATE_EN`.

Ports:

- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `reset`, in, 1: reset, **synchronous and active-low**.
- `arm`, in, 1: single-cycle pulse. Clears the buffer and starts capture.
- `cap_en`, in, 1: capture strobe; tie to `IRWrite`.
- `pc`, in, `DATA_W`: PC value sampled when `cap_en`=1.
- `ir`, in, `DATA_W`: instruction value sampled when `cap_en`=1.
- `trig_pc`, in, `DATA_W`: trigger PC value.
- `post_cnt`, in, `PTR_W`: number of entries to capture after the trigger entry. Sampled at the trigger.
- `rd_en`, in, 1: read request; honoured only in FROZEN.
- `rd_pc`, out, `DATA_W`: read-out PC.
- `rd_ir`, out, `DATA_W`: read-out IR.
- `rd_valid`, out, 1: `rd_pc`/`rd_ir` are valid this cycle.
- `armed`, out, 1: FSM is in ARMED or POST.
- `triggered`, out, 1: trigger has fired since the last `arm`.
- `frozen`, out, 1: FSM is in FROZEN.
- `count`, out, `PTR_W+1`: number of valid unread entries.

## Operation

- The FSM has four states: IDLE, ARMED, POST, FROZEN.
- Reset (`reset`=0 at an edge) forces the following:
  - State = IDLE.
  - `wr_ptr`, `rd_ptr`, `count`, `post_left` = 0.
  - All outputs = 0.
  - Storage contents are don't-care.
- `arm`=1 in any state, including mid-capture and mid-readout, takes priority over all other inputs. It causes:
  - State → ARMED.
  - `wr_ptr` = 0, `count` = 0, `triggered` = 0, `rd_valid` = 0.
  - No capture occurs in the `arm` cycle.
- IDLE: `cap_en` and `rd_en` are ignored.
- ARMED, on `cap_en`=1:
  - Write `{pc, ir}` at `wr_ptr`, then increment `wr_ptr` modulo `DEPTH`.
  - `count` increments, saturating at `DEPTH`. Once saturated, the oldest entry is overwritten.
- Trigger condition: `cap_en`=1 and `pc`==`trig_pc` while in ARMED. On the trigger:
  - The triggering entry is written.
  - `triggered` ← 1.
  - If `post_cnt`=0: state → FROZEN.
  - Otherwise: `post_left` ← `post_cnt`, state → POST.
- POST: each `cap_en`=1 writes one entry and decrements `post_left`. The write made with `post_left`=1 moves the state to FROZEN. Trigger matches in POST are ignored.
- Retention guarantee: `post_cnt` ≤ `DEPTH-1` by width, so the trigger entry is always retained.
- Entry to FROZEN: `rd_ptr` ← (`wr_ptr_next` − `count_next`) mod `DEPTH`, i.e. the oldest entry.
- FROZEN, on `rd_en`=1 with `count`>0:
  - Next cycle: `rd_valid`=1 and `rd_pc`/`rd_ir` = entry at `rd_ptr`.
  - `rd_ptr` increments modulo `DEPTH`; `count` decrements.
- FROZEN, on `rd_en`=1 with `count`=0: ignored, and `rd_valid`=0 next cycle.
- FROZEN holds until `arm` or reset. `cap_en` is ignored in FROZEN.
- `rd_pc`/`rd_ir` hold their last value when `rd_valid`=0.

## Timing

- Capture: the entry is written at the rising edge where `cap_en`=1. The trigger compare is combinational on the same-cycle `pc`.
- `count` and status outputs are registered and reflect a write one cycle after the strobe edge.
- `frozen` rises the cycle after the final capture edge.
- Read latency is 1 cycle from `rd_en` to `rd_valid`. Back-to-back `rd_en` yields one entry per cycle.
- `rd_en` in the same cycle as entry to FROZEN is ignored. Reads are accepted starting from the first cycle with `frozen`=1.
- Simultaneous `arm` and `cap_en`: `arm` wins and nothing is written.
- Simultaneous `arm` and `rd_en`: `arm` wins and `rd_valid`=0 next cycle.

## Configuration

- `TRACE_STATE_EN` defined:
  - Adds input `state` (`STATE_W`) and output `rd_state` (`STATE_W`).
  - The `state` value is captured with each entry and returned alongside `rd_pc` with identical timing.
  - `rd_state` resets to 0.
- `TRACE_STATE_EN` undefined: the ports and the storage for this field are absent. All other behaviour is identical.

## Test plan

All scenarios use `DEPTH`=8.

- **Reset:** hold `reset`=0 for 2 cycles → all outputs 0, `frozen`=0. Then pulse `rd_en` → `rd_valid` stays 0.
- **Basic trigger:** arm; 5 captures with pc = 0x00, 0x04, 0x08, 0x0C, 0x10; `trig_pc`=0x08, `post_cnt`=2 → frozen after pc 0x10, `count`=5. Reads return pc 0x00..0x10 in order, then `rd_valid`=0.
- **Wrap and overwrite:** arm; 12 captures with pc = 0x00..0x2C; trigger at 0x2C, `post_cnt`=0 → `count`=8, reads return 0x10..0x2C.
- **Max post:** `post_cnt`=7 with trigger at the first capture, followed by 10 more captures → exactly 7 post entries captured. Oldest returned entry = trigger pc; `count`=8.
- **Re-arm mid-readout:** read 3 of 8 entries, then `arm` → `count`=0, `armed`=1, `triggered`=0. A following `rd_en` gives `rd_valid`=0.
- **Collisions:** `arm` and `cap_en` in the same cycle → `count`=0 next cycle. With `TRACE_STATE_EN`, `rd_state` matches the captured `state` on every read.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Circular {PC, IR} trace capture with PC-match trigger, post-trigger count and oldest-first readout.
// Optional macro TRACE_STATE_EN adds a per-entry FSM state field (state in, rd_state out).
module cpu_trace_buffer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int STATE_W = 4
) (
`ifdef TRACE_STATE_EN
    input  logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] rd_state,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [PTR_W-1:0]  post_cnt,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_ir,
    output logic              rd_valid,
    output logic              armed,
    output logic              triggered,
    output logic              frozen,
    output logic [PTR_W:0]    count
);

    localparam int CNT_W = PTR_W + 1;
`ifdef TRACE_STATE_EN
    localparam int ENTRY_W = 2 * DATA_W + STATE_W;
`else
    localparam int ENTRY_W = 2 * DATA_W + 0 * STATE_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   post_left_q, post_left_d;
    logic               triggered_q, triggered_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ENTRY_W-1:0] rd_entry_q, rd_entry_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_data_s;
    logic               wr_en_s;

`ifdef TRACE_STATE_EN
    assign wr_data_s = {state, pc, ir};
    assign rd_state  = rd_entry_q[ENTRY_W-1 -: STATE_W];
`else
    assign wr_data_s = {pc, ir};
`endif

    assign rd_ir     = rd_entry_q[DATA_W-1:0];
    assign rd_pc     = rd_entry_q[2*DATA_W-1:DATA_W];
    assign rd_valid  = rd_valid_q;
    assign triggered = triggered_q;
    assign count     = count_q;
    assign armed     = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign frozen    = (state_q == ST_FROZEN);

    // Next-state, pointer, counter and read-port logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_left_d = post_left_q;
        triggered_d = triggered_q;
        rd_valid_d  = 1'b0;
        rd_entry_d  = rd_entry_q;
        wr_en_s     = 1'b0;

        if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = PTR_W'(0);
            count_d     = CNT_W'(0);
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    if (cap_en) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        if (count_q == CNT_W'(DEPTH)) begin
                            count_d = count_q;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                        if (state_q == ST_ARMED) begin
                            if (pc == trig_pc) begin
                                triggered_d = 1'b1;
                                if (post_cnt == PTR_W'(0)) begin
                                    state_d = ST_FROZEN;
                                end else begin
                                    post_left_d = post_cnt;
                                    state_d     = ST_POST;
                                end
                            end else begin
                                state_d = ST_ARMED;
                            end
                        end else begin
                            post_left_d = post_left_q - PTR_W'(1);
                            if (post_left_q == PTR_W'(1)) begin
                                state_d = ST_FROZEN;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                        // A full buffer wraps count's low bits to 0, so rd_ptr lands on wr_ptr.
                        rd_ptr_d = wr_ptr_d - count_d[PTR_W-1:0];
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                ST_FROZEN: begin
                    if (rd_en && (count_q != CNT_W'(0))) begin
                        rd_valid_d = 1'b1;
                        rd_entry_d = mem_q[rd_ptr_q];
                        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                        count_d    = count_q - CNT_W'(1);
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Control and read-port registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= PTR_W'(0);
            rd_ptr_q    <= PTR_W'(0);
            count_q     <= CNT_W'(0);
            post_left_q <= PTR_W'(0);
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_entry_q  <= ENTRY_W'(0);
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_left_q <= post_left_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
            rd_entry_q  <= rd_entry_d;
        end
    end

    // Trace storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

endmodule
